// File: rtl/mult_seq_ctrl.sv
// Sequencer and valid/ready handshake for a shift-add multiplier datapath.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands skip the datapath and go straight to DONE.
module mult_seq_ctrl #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 6
) (
    input  logic                Clock,
    input  logic                iReset_n,
    input  logic                iValid,
    output logic                oReady,
    input  logic [SIZE-1:0]     iData_A,
    input  logic [SIZE-1:0]     iData_B,
    output logic                oLoad,
    output logic [SIZE-1:0]     oOp_A,
    output logic [SIZE-1:0]     oOp_B,
    input  logic [2*SIZE-1:0]   iProduct,
    output logic                oValid,
    input  logic                iReady,
    output logic [2*SIZE-1:0]   oResult,
    output logic                oBusy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4,
        BYPASS  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SIZE-1:0]     op_a_q, op_a_d;
    logic [SIZE-1:0]     op_b_q, op_b_d;
    logic [2*SIZE-1:0]   result_q, result_d;

    always_ff @(posedge Clock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (iValid) begin
                    op_a_d = iData_A;
                    op_b_d = iData_B;
`ifdef MULT_ZERO_BYPASS_EN
                    if ((iData_A == '0) || (iData_B == '0)) begin
                        state_d = BYPASS;
                    end else begin
                        state_d = LOAD;
                    end
`else
                    state_d = LOAD;
`endif
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                result_d = iProduct;
                state_d  = DONE;
            end
            // Zero-operand shortcut: the product is known without the datapath.
            BYPASS: begin
                result_d = '0;
                state_d  = DONE;
            end
            DONE: begin
                if (iReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and strobe outputs are pure state decodes, so no input reaches an output.
    assign oReady  = (state_q == IDLE);
    assign oLoad   = (state_q == LOAD);
    assign oValid  = (state_q == DONE);
    assign oBusy   = (state_q != IDLE);
    assign oOp_A   = op_a_q;
    assign oOp_B   = op_b_q;
    assign oResult = result_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl with a behavioural shift-add datapath and a plain A*B reference.
module tb_mult_seq_ctrl;

    localparam int SIZE = 32;

    logic                Clock;
    logic                iReset_n;
    logic                iValid;
    logic                oReady;
    logic [SIZE-1:0]     iData_A;
    logic [SIZE-1:0]     iData_B;
    logic                oLoad;
    logic [SIZE-1:0]     oOp_A;
    logic [SIZE-1:0]     oOp_B;
    logic [2*SIZE-1:0]   iProduct;
    logic                oValid;
    logic                iReady;
    logic [2*SIZE-1:0]   oResult;
    logic                oBusy;

    int vectors;
    int miscompares;

    mult_seq_ctrl #(.SIZE(SIZE), .CNT_W(6)) dut (
        .Clock    (Clock),
        .iReset_n (iReset_n),
        .iValid   (iValid),
        .oReady   (oReady),
        .iData_A  (iData_A),
        .iData_B  (iData_B),
        .oLoad    (oLoad),
        .oOp_A    (oOp_A),
        .oOp_B    (oOp_B),
        .iProduct (iProduct),
        .oValid   (oValid),
        .iReady   (iReady),
        .oResult  (oResult),
        .oBusy    (oBusy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Shift-add datapath: clears on oLoad, then adds one partial product per edge.
    logic [2*SIZE-1:0] dp_acc;
    logic [5:0]        dp_i;
    always_ff @(posedge Clock or negedge iReset_n) begin
        if (!iReset_n) begin
            dp_acc <= '0;
            dp_i   <= '0;
        end else if (oLoad) begin
            dp_acc <= '0;
            dp_i   <= '0;
        end else if (int'(dp_i) < SIZE) begin
            if (oOp_B[dp_i[4:0]]) dp_acc <= dp_acc + ({{SIZE{1'b0}}, oOp_A} << dp_i);
            dp_i <= dp_i + 6'd1;
        end
    end
    assign iProduct = dp_acc;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_ready"}, oReady, 1'b1);
        check1({tag, "_busy"},  oBusy,  1'b0);
        check1({tag, "_load"},  oLoad,  1'b0);
        check1({tag, "_valid"}, oValid, 1'b0);
        check64({tag, "_opa"},  {32'b0, oOp_A}, 64'd0);
        check64({tag, "_opb"},  {32'b0, oOp_B}, 64'd0);
        check64({tag, "_res"},  oResult, 64'd0);
    endtask

    // One full transaction: accept, wait for result, optional backpressure, handshake.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int hold,
                           input bit poke, input string tag);
        logic [63:0] expv;
        int          exp_lat;
        int          exp_loads;
        int          edges;
        int          loads;
        bit          busy_ok;
        bit          hold_ok;
        expv      = {32'b0, a} * {32'b0, b};
        exp_lat   = SIZE + 2;
        exp_loads = 1;
`ifdef MULT_ZERO_BYPASS_EN
        if (a == 32'd0 || b == 32'd0) begin
            exp_lat   = 1;
            exp_loads = 0;
        end
`endif
        check1({tag, "_ready_idle"}, oReady, 1'b1);
        iValid  = 1'b1;
        iData_A = a;
        iData_B = b;
        iReady  = (hold == 0);
        tick();
        if (poke) begin
            iData_A = 32'd2;
            iData_B = 32'd2;
        end else begin
            iValid  = 1'b0;
            iData_A = $urandom;
            iData_B = $urandom;
        end
        edges   = 0;
        loads   = 0;
        busy_ok = 1'b1;
        while (oValid !== 1'b1 && edges < 200) begin
            if (oLoad === 1'b1) loads++;
            if (oOp_A !== a || oOp_B !== b || oBusy !== 1'b1 || oReady !== 1'b0) busy_ok = 1'b0;
            tick();
            edges++;
        end
        iValid = 1'b0;
        check_int({tag, "_latency"}, edges, exp_lat);
        check_int({tag, "_load_cycles"}, loads, exp_loads);
        check1({tag, "_busy_stable"}, busy_ok, 1'b1);
        check64({tag, "_result"}, oResult, expv);
        check1({tag, "_ready_done"}, oReady, 1'b0);
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (oValid !== 1'b1 || oResult !== expv || oReady !== 1'b0) hold_ok = 1'b0;
        end
        if (hold > 0) check1({tag, "_hold_stable"}, hold_ok, 1'b1);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        check1({tag, "_valid_drop"}, oValid, 1'b0);
        check1({tag, "_ready_back"}, oReady, 1'b1);
        check1({tag, "_busy_drop"},  oBusy,  1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        vectors     = 0;
        miscompares = 0;
        iReset_n    = 1'b0;
        iValid      = 1'b0;
        iReady      = 1'b0;
        iData_A     = '0;
        iData_B     = '0;
        #12;
        check_reset_outputs("por");
        @(negedge Clock);
        iReset_n = 1'b1;
        tick();

        run_txn(32'd3, 32'd5, 0, 1'b0, "a3b5");
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "max");
        run_txn(32'd7, 32'd9, 10, 1'b0, "bp7x9");
        run_txn(32'd4, 32'd4, 0, 1'b1, "poke4x4");

        // Reset while RUN has counted up to 10.
        iValid  = 1'b1;
        iData_A = 32'd11;
        iData_B = 32'd13;
        tick();
        iValid = 1'b0;
        repeat (11) tick();
        check1("midrun_busy", oBusy, 1'b1);
        #2;
        iReset_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        @(negedge Clock);
        iReset_n = 1'b1;
        tick();
        run_txn(32'd6, 32'd7, 0, 1'b0, "after_rst");

        run_txn(32'd0, 32'd123, 2, 1'b0, "zeroA");

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 3) rb = 32'd0;
            run_txn(ra, rb, int'($urandom_range(0, 3)), 1'b0, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
